// File: rtl/alu_mmio_ctrl_if.sv
// alu_mmio_ctrl_if: peripheral bus between the bus decoder and alu_mmio_ctrl.
//
// Handshake:
//   The master raises req with we/addr/wdata stable and holds them until it
//   sees ack. The slave accepts at a rising edge where req=1, ack=0 and the
//   access is not stalled. ack is then high for exactly the next cycle, and
//   rdata carries the read value during that cycle (0 otherwise). req is
//   ignored while ack=1, so every access takes at least two cycles.
//
// Signals: req, we, addr, wdata (master -> slave); rdata, ack (slave -> master).
interface alu_mmio_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/alu_mmio_ctrl.sv
// alu_mmio_ctrl: memory-mapped front end for a combinational ALU.
// The CPU writes OPA/OPB/OP; a valid OP write launches one EXEC cycle, after
// which the ALU result and {C,N,Z} flags are captured into read-only regs.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus            alu_mmio_ctrl_if slave (req/we/addr/wdata/rdata/ack)
//   alu_a, alu_b   operands to the ALU (OPA/OPB registers)
//   alu_op         opcode to the ALU (OP register)
//   alu_dout       ALU result
//   alu_flags      ALU flags, bit2 C, bit1 N, bit0 Z
//   irq            level interrupt = done & irq_en
//   dbg_state      FSM state (0 IDLE, 1 EXEC)
//
// Map: 0 OPA, 1 OPB, 2 OP, 3 RESULT, 4 FLAGS, 5 STATUS {err,done,busy},
//      6 CTRL {clr(W1C, reads 0), irq_en}, 7 reads 0.
module alu_mmio_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_mmio_ctrl_if.slave        bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0] alu_dout,
  input  logic [DATA_WIDTH-1:0] alu_flags,
  output logic                  irq,
  output logic                  dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] OFF_OPA    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_OPB    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_OP     = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_RESULT = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OFF_FLAGS  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(6);
  localparam logic [DATA_WIDTH-1:0] OP_MAX     = DATA_WIDTH'(9);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t state, state_next;
  logic   busy, capture;

  logic [DATA_WIDTH-1:0] opa, opb, op_reg, result, read_val;
  logic [2:0]            flags;
  logic                  done, err, irq_en;
  logic                  stall, accept, wr, launch, bad_op, clr;
  logic                  unused_flags;

  // Only C/N/Z are captured from the ALU flag word.
  assign unused_flags = ^alu_flags[DATA_WIDTH-1:3];

  // Operand/result registers are frozen while the ALU is computing.
  assign stall  = busy && (bus.addr <= OFF_FLAGS);
  assign accept = bus.req && !bus.ack && !stall;
  assign wr     = accept && bus.we;
  assign launch = wr && (bus.addr == OFF_OP) && (bus.wdata <= OP_MAX);
  assign bad_op = wr && (bus.addr == OFF_OP) && (bus.wdata > OP_MAX);
  assign clr    = wr && (bus.addr == OFF_CTRL) && bus.wdata[1];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state; EXEC always lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (launch) state_next = EXEC;
      EXEC: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = 1'b0;
    capture = 1'b0;
    if (state == EXEC) begin
      busy    = 1'b1;
      capture = 1'b1;
    end
  end

  // Register writes and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      op_reg <= '0;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (wr) begin
        case (bus.addr)
          OFF_OPA:  opa    <= bus.wdata;
          OFF_OPB:  opb    <= bus.wdata;
          OFF_OP:   op_reg <= bus.wdata;
          OFF_CTRL: irq_en <= bus.wdata[0];
          default:  ;
        endcase
      end
      if (clr || launch) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (bad_op) begin
        done <= 1'b0;
        err  <= 1'b1;
      end
      // Listed last so a coincident clear loses to the capture.
      if (capture) begin
        result <= alu_dout;
        flags  <= alu_flags[2:0];
        done   <= 1'b1;
      end
    end
  end

  // Read mux, sampled at the accept edge
  always_comb begin
    read_val = '0;
    case (bus.addr)
      OFF_OPA:    read_val = opa;
      OFF_OPB:    read_val = opb;
      OFF_OP:     read_val = op_reg;
      OFF_RESULT: read_val = result;
      OFF_FLAGS:  read_val = {{(DATA_WIDTH-3){1'b0}}, flags};
      OFF_STATUS: read_val = {{(DATA_WIDTH-3){1'b0}}, err, done, busy};
      OFF_CTRL:   read_val = {{(DATA_WIDTH-1){1'b0}}, irq_en};
      default:    read_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= accept;
      bus.rdata <= (accept && !bus.we) ? read_val : '0;
    end
  end

  assign alu_a     = opa;
  assign alu_b     = opb;
  assign alu_op    = op_reg;
  assign irq       = done & irq_en;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_mmio_ctrl.sv
module tb_alu_mmio_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  localparam logic [AW-1:0] A_OPA = 3'd0, A_OPB = 3'd1, A_OP = 3'd2, A_RES = 3'd3,
                            A_FLG = 3'd4, A_STS = 3'd5, A_CTL = 3'd6, A_NONE = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mmio_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  logic [DW-1:0] alu_a, alu_b, alu_op, alu_dout, alu_flags;
  logic          irq, dbg_state;

  alu_mmio_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_dout  (alu_dout),
    .alu_flags (alu_flags),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // ---------------- combinational ALU stand-in ----------------
  logic [DW:0] wide;
  always_comb begin
    wide = '0;
    case (alu_op)
      16'd0: wide = {1'b0, alu_a} + {1'b0, alu_b};
      16'd1: wide = {1'b0, alu_a} - {1'b0, alu_b};
      16'd2: wide = {1'b0, alu_a >> alu_b[3:0]};
      16'd3: wide = {1'b0, alu_a << alu_b[3:0]};
      16'd4: wide = {1'b0, alu_a | alu_b};
      16'd5: wide = {1'b0, ~(alu_a | alu_b)};
      16'd6: wide = {1'b0, alu_a & alu_b};
      16'd7: wide = {1'b0, ~(alu_a & alu_b)};
      16'd8: wide = {1'b0, alu_a ^ alu_b};
      16'd9: wide = {1'b0, ~alu_a};
      default: wide = '0;
    endcase
    alu_dout  = wide[DW-1:0];
    alu_flags = {13'd0, wide[DW], wide[DW-1], (wide[DW-1:0] == '0)};
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  int            last_edges;
  logic [DW-1:0] rd_val;

  task automatic bus_xfer(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata);
    bus_if.req   = 1'b1;
    bus_if.we    = we;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
    last_edges   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      last_edges++;
      if (bus_if.ack) break;
    end
    check("ack seen", {15'd0, bus_if.ack}, 16'd1);
    rdata      = bus_if.rdata;
    bus_if.req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [DW-1:0] dummy;
    bus_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus_xfer(1'b0, addr, '0, rd_val);
    check(tag, rd_val, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst ack", {15'd0, bus_if.ack}, 16'd0);
    check("rst rdata", bus_if.rdata, 16'h0000);
    check("rst alu_a", alu_a, 16'h0000);
    check("rst irq", {15'd0, irq}, 16'd0);
    check("rst state", {15'd0, dbg_state}, 16'd0);
    @(negedge clk);
    rd_chk("rst status", A_STS, 16'h0000);

    // ADD with carry: 0xFFFF + 1
    wr(A_OPA, 16'hFFFF);
    wr(A_OPB, 16'h0001);
    wr(A_OP, 16'h0000);
    rd_chk("add result", A_RES, 16'h0000);
    rd_chk("add flags", A_FLG, 16'h0005);
    rd_chk("add status", A_STS, 16'h0002);

    // SUB with borrow; RESULT read issued right after the OP ack
    wr(A_OPA, 16'h0003);
    wr(A_OPB, 16'h0005);
    wr(A_OP, 16'h0001);
    check("sub exec state", {15'd0, dbg_state}, 16'd1);
    rd_chk("sub result", A_RES, 16'hFFFE);
    check("sub read edges", 16'(last_edges), 16'd2);
    rd_chk("sub flags", A_FLG, 16'h0006);

    // Invalid opcode: err set, done cleared, RESULT/FLAGS untouched
    wr(A_OP, 16'h000C);
    check("bad op state", {15'd0, dbg_state}, 16'd0);
    rd_chk("bad op status", A_STS, 16'h0004);
    rd_chk("bad op result", A_RES, 16'hFFFE);
    rd_chk("bad op flags", A_FLG, 16'h0006);
    rd_chk("bad op reg", A_OP, 16'h000C);
    wr(A_CTL, 16'h0002);
    rd_chk("clr status", A_STS, 16'h0000);
    rd_chk("clr ctrl", A_CTL, 16'h0000);

    // Offset 7 and writes to RO registers
    rd_chk("off7 read", A_NONE, 16'h0000);
    wr(A_RES, 16'hABCD);
    rd_chk("ro result", A_RES, 16'hFFFE);

    // Interrupt and stall during EXEC
    wr(A_CTL, 16'h0001);
    wr(A_OPA, 16'h00F0);
    wr(A_OPB, 16'h0F0F);
    wr(A_OP, 16'h0008);
    check("xor exec state", {15'd0, dbg_state}, 16'd1);
    check("xor alu_op", alu_op, 16'h0008);
    check("irq low in exec", {15'd0, irq}, 16'd0);
    wr(A_OPA, 16'h1111);
    check("opa wr edges", 16'(last_edges), 16'd2);
    check("irq after capture", {15'd0, irq}, 16'd1);
    rd_chk("xor result", A_RES, 16'h0FFF);
    rd_chk("xor flags", A_FLG, 16'h0000);
    rd_chk("opa after stall", A_OPA, 16'h1111);
    rd_chk("ctrl irq_en", A_CTL, 16'h0001);
    rd_chk("xor status", A_STS, 16'h0002);
    wr(A_CTL, 16'h0003);
    check("irq after clear", {15'd0, irq}, 16'd0);
    rd_chk("status after clear", A_STS, 16'h0000);

    // Asynchronous reset mid-cycle, while ack/rdata are active
    rd_chk("opa pre reset", A_OPA, 16'h1111);
    #3 rst = 1'b1;
    #1;
    check("async ack", {15'd0, bus_if.ack}, 16'd0);
    check("async rdata", bus_if.rdata, 16'h0000);
    check("async alu_a", alu_a, 16'h0000);
    check("async alu_b", alu_b, 16'h0000);
    check("async alu_op", alu_op, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("async status", A_STS, 16'h0000);

    // Reset during EXEC discards the in-flight result
    wr(A_CTL, 16'h0001);
    wr(A_OPA, 16'h8000);
    wr(A_OPB, 16'h8001);
    wr(A_OP, 16'h0000);
    check("pre rst exec", {15'd0, dbg_state}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("exec rst state", {15'd0, dbg_state}, 16'd0);
    check("exec rst irq", {15'd0, irq}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("exec rst result", A_RES, 16'h0000);
    rd_chk("exec rst status", A_STS, 16'h0000);
    check("exec rst irq2", {15'd0, irq}, 16'd0);

    // Normal launch after reset
    wr(A_OPA, 16'h0002);
    wr(A_OPB, 16'h0003);
    wr(A_OP, 16'h0000);
    rd_chk("post rst result", A_RES, 16'h0005);
    rd_chk("post rst flags", A_FLG, 16'h0000);
    rd_chk("post rst status", A_STS, 16'h0002);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
